// File: rtl/fetch_pkg.sv
// Shared fetch definitions: instruction size, queue entry width and the
// per-lane valid mask used by both fetch and decode.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned MAX_ISSUE_W = 4;

  // Packed queue entry: {instr[issue_w-1:0], pc, lane_valid}.
  function automatic int unsigned entry_width(input int unsigned dw, input int unsigned iw);
    return iw * dw + dw + iw;
  endfunction

  // Lanes below the word index of the fetch PC within its bundle are dropped;
  // they precede an unaligned redirect target.
  function automatic logic [MAX_ISSUE_W-1:0] lane_mask(input logic [1:0]  word_idx,
                                                       input int unsigned issue_w);
    logic [MAX_ISSUE_W-1:0] m;
    int unsigned            first_lane;
    first_lane = 32'(word_idx) & (issue_w - 1);
    m = '0;
    for (int unsigned i = 0; i < MAX_ISSUE_W; i++) begin
      m[i] = (i < issue_w) && (i >= first_lane);
    end
    return m;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush.
//   clk, rst   : clock, asynchronous active-low reset
//   flush_i    : discard all entries; overrides push_i and pop_i
//   push_i     : write wdata_i at the tail (caller guarantees room or a pop)
//   pop_i      : drop the head entry (caller guarantees non-empty)
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
//   head_o     : head entry, zero while empty
module fetch_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push_i & ~flush_i;
  assign w_pop  = pop_i & ~flush_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // When full, a push alongside a pop reuses the slot being read this cycle.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata_i;
  end

  assign full_o  = (r_count == CntW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign head_o  = empty_o ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Multi-issue fetch stage: PC register, bundle-aligned instruction fetch and a
// bundle queue decoupling fetch from decode.
//   clk, rst       : clock, asynchronous active-low reset
//   imem_addr_o    : bundle-aligned fetch address (combinational instrmem read)
//   imem_rdata_i   : ISSUE_W instructions, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   redirect_i     : flush queue and load redirect_pc_i into the PC
//   redirect_pc_i  : word-aligned redirect target
//   out_valid_o    : head bundle valid
//   out_ready_i    : consumer takes the head bundle
//   bundle_o       : head bundle instructions
//   bundle_pc_o    : aligned PC of the head bundle
//   lane_valid_o   : per-lane valid mask of the head bundle
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ISSUE_W    = 2,
  parameter int unsigned            DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [DATA_WIDTH-1:0]         imem_addr_o,
  input  logic [ISSUE_W*DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                          redirect_i,
  input  logic [DATA_WIDTH-1:0]         redirect_pc_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [ISSUE_W*DATA_WIDTH-1:0] bundle_o,
  output logic [DATA_WIDTH-1:0]         bundle_pc_o,
  output logic [ISSUE_W-1:0]            lane_valid_o
);

  localparam int unsigned OFF = $clog2(ISSUE_W) + 2;
  localparam int unsigned EW  = entry_width(DATA_WIDTH, ISSUE_W);

  logic [DATA_WIDTH-1:0]  r_pc;
  logic [DATA_WIDTH-1:0]  w_fetch_addr;
  logic [MAX_ISSUE_W-1:0] w_mask_all;
  logic [ISSUE_W-1:0]     w_mask;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_push;
  logic [EW-1:0]          w_head;
  logic                   w_unused;

  assign w_fetch_addr = {r_pc[DATA_WIDTH-1:OFF], {OFF{1'b0}}};
  assign imem_addr_o  = w_fetch_addr;

  assign w_mask_all = lane_mask(r_pc[3:2], ISSUE_W);
  assign w_mask     = w_mask_all[ISSUE_W-1:0];
  // PC bits [1:0] stay zero (word-aligned targets) and upper mask lanes may not exist.
  assign w_unused   = ^{w_mask_all, r_pc[1:0]};

  assign w_pop  = ~w_empty & out_ready_i;
  assign w_push = ~redirect_i & (~w_full | w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC;
    end else if (redirect_i) begin
      r_pc <= redirect_pc_i;
    end else if (w_push) begin
      r_pc <= w_fetch_addr + DATA_WIDTH'(ISSUE_W * INSTR_BYTES);
    end
  end

  fetch_fifo #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i ({imem_rdata_i, w_fetch_addr, w_mask}),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head)
  );

  assign out_valid_o = ~w_empty;
  assign {bundle_o, bundle_pc_o, lane_valid_o} = w_head;

endmodule
